noc_vc_input_buffer: RTL and testbench
======================================

Name: noc_vc_input_buffer

Overview:
Per-virtual-channel flit buffer at a router input port. It accepts flits on a shared flit bus, with one valid/ready pair per VC, and stores them in independent per-VC FIFOs. A packet-locked round-robin arbiter drains the FIFOs onto a single valid/ready output toward the switch/route stage. Parameter defaults match the NoC default configuration: 2 VCs, 256-bit data.

Parameters:
VIRTUAL_CHANNELS  2    number of VCs; ≥1
FLIT_WIDTH  256  flit payload width, tail bit excluded
DEPTH  4    entries per VC FIFO; ≥1, need not be a power of two
CW  $clog2(DEPTH+1)  derived; occupancy count width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_valid  in  VIRTUAL_CHANNELS  per-VC input valid
o_ready  out  VIRTUAL_CHANNELS  per-VC input ready
i_flit  in  FLIT_WIDTH  shared input flit payload
i_tail  in  1  input flit is the last flit of its packet
o_valid  out  1  output flit valid
i_ready  in  1  downstream ready
o_flit  out  FLIT_WIDTH  output flit payload
o_tail  out  1  output tail bit
o_vc  out  VIRTUAL_CHANNELS  one-hot VC of the output flit; all-zero when o_valid=0

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: all FIFOs empty, rd/wr pointers 0, arbiter pointer = VC0, lock cleared. After reset, o_valid=0, o_vc=0, o_ready=all-ones, o_flit/o_tail don't-care (drive 0).
- Write: VC v is written when i_valid[v] && o_ready[v]. o_ready[v] = !full[v], registered-state based, with no combinational path from i_valid or i_ready.
- Writing to a full VC is blocked. There is no same-cycle read-frees-slot pass-through.
- At most one i_valid bit may be set per cycle. If several are set, only the lowest index with ready=1 is written. The others see handshake but are not written; the bench flags this as a protocol error.
- Pointers wrap from DEPTH-1 to 0. Count per VC is 0..DEPTH. Full when count==DEPTH, empty when count==0.
- Latency: a flit written in cycle N can appear on o_flit in cycle N+1 at the earliest. There is no bypass.
- Simultaneous read and write on the same VC is allowed (count unchanged) when the VC is not full.
- Arbiter grant:
  - When locked, or when o_valid && !i_ready was true in the previous cycle: grant is held.
  - Otherwise: the first non-empty VC searched from the arbiter pointer upward, with wrap.
- o_valid = granted VC non-empty. The output payload and o_vc come from the granted FIFO head.
- Output stability: once o_valid=1, o_flit/o_tail/o_vc are stable until the handshake.
- Lock set: on a handshake of a non-tail flit, lock onto that VC. Other VCs are not served until that VC's tail flit handshakes.
- Lock release: on tail handshake, clear lock and move the arbiter pointer to (granted VC + 1) mod VIRTUAL_CHANNELS.
- Locked VC empty mid-packet: o_valid=0, grant held, no other VC served.
- Single-flit packet (head is tail): no lock; the pointer advances on its handshake.
- Reset asserted mid-packet: everything returns to the reset state immediately. Buffered flits are discarded.

Optional Feature:
NOC_VC_INPUT_BUFFER_COUNT_EN
- Defined: adds output port o_count, width VIRTUAL_CHANNELS*CW, VC v at [v*CW +: CW], giving the registered occupancy (reset value 0).
- Undefined: the port is absent; internal full/empty logic is unchanged.

Test Plan:
- Reset then idle: o_ready=2'b11, o_valid=0, o_vc=0; write one tail flit 0xA5 on VC0 at cycle 1 -> o_valid=1 at cycle 2 with o_flit=0xA5, o_vc=2'b01, o_tail=1.
- Fill VC1 with 4 flits, i_ready=0 -> o_ready[1]=0 after the 4th write; a 5th i_valid[1] is not accepted; o_ready[0] stays 1; drain with i_ready=1 -> the 4 flits emerge in order, one per cycle.
- 3-flit packet on VC0 and 3-flit packet on VC1, both buffered, i_ready=1 -> output VC0,VC0,VC0(tail),VC1,VC1,VC1(tail); no interleaving.
- Single-flit tail packets continuously on both VCs -> output alternates VC0,VC1,VC0,VC1.
- Backpressure: o_valid=1 on VC1 with i_ready=0 for 3 cycles while VC0 gets a flit -> o_vc stays 2'b10 and o_flit is unchanged until the handshake.
- Locked VC0 runs empty after its head flit while VC1 holds data -> o_valid=0 and no VC1 flit is output until VC0's tail arrives and handshakes; reset pulse mid-packet -> o_valid=0, o_ready=all-ones, counts 0 (with the count macro defined).

Source files
------------

// File: rtl/noc_vc_input_buffer_if.sv
// Flit bus between an upstream link and the VC input buffer.
// master = upstream/downstream environment, slave = the buffer itself.
interface noc_vc_input_buffer_if #(
    parameter int VIRTUAL_CHANNELS = 2,
    parameter int FLIT_WIDTH       = 256
);
    logic [VIRTUAL_CHANNELS-1:0] i_valid;
    logic [VIRTUAL_CHANNELS-1:0] o_ready;
    logic [FLIT_WIDTH-1:0]       i_flit;
    logic                        i_tail;
    logic                        o_valid;
    logic                        i_ready;
    logic [FLIT_WIDTH-1:0]       o_flit;
    logic                        o_tail;
    logic [VIRTUAL_CHANNELS-1:0] o_vc;

    modport master (
        output i_valid, i_flit, i_tail, i_ready,
        input  o_ready, o_valid, o_flit, o_tail, o_vc
    );

    modport slave (
        input  i_valid, i_flit, i_tail, i_ready,
        output o_ready, o_valid, o_flit, o_tail, o_vc
    );
endinterface

// File: rtl/noc_vc_input_buffer.sv
// Per-VC flit FIFOs drained by a packet-locked round-robin arbiter.
// Optional macro NOC_VC_INPUT_BUFFER_COUNT_EN exposes per-VC occupancy on o_count.
module noc_vc_input_buffer #(
    parameter int VIRTUAL_CHANNELS = 2,
    parameter int FLIT_WIDTH       = 256,
    parameter int DEPTH            = 4,
    localparam int CW              = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    noc_vc_input_buffer_if.slave bus
`ifdef NOC_VC_INPUT_BUFFER_COUNT_EN
    ,
    output logic [VIRTUAL_CHANNELS*CW-1:0] o_count
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int VW = (VIRTUAL_CHANNELS > 1) ? $clog2(VIRTUAL_CHANNELS) : 1;

    typedef logic [FLIT_WIDTH:0] entry_t;  // {tail, payload}

    logic [VIRTUAL_CHANNELS-1:0] full, empty, wr_req, wr_en, rd_en;
    entry_t                      head_vc [VIRTUAL_CHANNELS];
    entry_t                      head;
    logic [VW-1:0]               grant_q, grant_d, arb_ptr_q, arb_ptr_d;
    logic                        lock_q, lock_d, hold_q, hold_d;
    logic                        out_valid, handshake;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Only the lowest-index ready requester is written if several collide.
    assign wr_req      = bus.i_valid & ~full;
    assign wr_en       = wr_req & ~(wr_req - VIRTUAL_CHANNELS'(1));
    assign bus.o_ready = ~full;

    for (genvar v = 0; v < VIRTUAL_CHANNELS; v++) begin : g_vc
        entry_t        mem_q [DEPTH];
        logic [PW-1:0] wr_ptr_q, rd_ptr_q;
        logic [CW-1:0] count_q;

        assign full[v]    = (count_q == CW'(DEPTH));
        assign empty[v]   = (count_q == '0);
        assign rd_en[v]   = handshake && (grant_d == VW'(v));
        assign head_vc[v] = mem_q[rd_ptr_q];

        // NOTE: the storage array has no reset; validity is carried by count_q alone.
        always_ff @(posedge clk) begin
            if (wr_en[v]) mem_q[wr_ptr_q] <= {bus.i_tail, bus.i_flit};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (wr_en[v]) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (rd_en[v]) rd_ptr_q <= ptr_inc(rd_ptr_q);
                case ({wr_en[v], rd_en[v]})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end

`ifdef NOC_VC_INPUT_BUFFER_COUNT_EN
        assign o_count[v*CW +: CW] = count_q;
`endif
    end

    always_comb begin : arb_comb
        logic          found;
        logic [VW-1:0] cand;
        // NOTE: every output of this block gets a default first, so no latches are inferred.
        grant_d   = grant_q;
        lock_d    = lock_q;
        arb_ptr_d = arb_ptr_q;
        found     = 1'b0;
        cand      = '0;
        // A packet in flight or a stalled output keeps the current grant.
        if (!(lock_q || hold_q)) begin
            for (int k = 0; k < VIRTUAL_CHANNELS; k++) begin
                cand = VW'((int'(arb_ptr_q) + k) % VIRTUAL_CHANNELS);
                if (!found && !empty[cand]) begin
                    grant_d = cand;
                    found   = 1'b1;
                end
            end
        end
        head      = head_vc[grant_d];
        out_valid = !empty[grant_d];
        handshake = out_valid && bus.i_ready;
        hold_d    = out_valid && !bus.i_ready;
        if (handshake) begin
            if (head[FLIT_WIDTH]) begin
                lock_d    = 1'b0;
                arb_ptr_d = (grant_d == VW'(VIRTUAL_CHANNELS - 1)) ? '0 : grant_d + VW'(1);
            end else begin
                lock_d = 1'b1;
            end
        end
    end

    assign bus.o_valid = out_valid;
    assign bus.o_flit  = out_valid ? head[FLIT_WIDTH-1:0] : '0;
    assign bus.o_tail  = out_valid && head[FLIT_WIDTH];
    assign bus.o_vc    = out_valid ? (VIRTUAL_CHANNELS'(1) << grant_d) : '0;

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= '0;
            arb_ptr_q <= '0;
            lock_q    <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            arb_ptr_q <= arb_ptr_d;
            lock_q    <= lock_d;
            hold_q    <= hold_d;
        end
    end
endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Scoreboard bench for noc_vc_input_buffer: per-VC queues plus packet-level arbitration model.
// o_count is checked when NOC_VC_INPUT_BUFFER_COUNT_EN is defined.
module tb_noc_vc_input_buffer;
    localparam int VC    = 2;
    localparam int FW    = 256;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    noc_vc_input_buffer_if #(.VIRTUAL_CHANNELS(VC), .FLIT_WIDTH(FW)) bus ();
`ifdef NOC_VC_INPUT_BUFFER_COUNT_EN
    logic [VC*CW-1:0] o_count;
`endif

    noc_vc_input_buffer #(.VIRTUAL_CHANNELS(VC), .FLIT_WIDTH(FW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef NOC_VC_INPUT_BUFFER_COUNT_EN
        ,
        .o_count (o_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [FW:0] act, input logic [FW:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue of {tail,payload} per VC, plus packet lock state.
    logic [FW:0] mq [VC][$];
    int          m_ptr   = 0;
    int          m_grant = 0;
    bit          m_lock  = 1'b0;
    bit          m_hold  = 1'b0;

    function automatic int cur_grant();
        if (m_lock || m_hold) return m_grant;
        for (int k = 0; k < VC; k++)
            if (mq[(m_ptr + k) % VC].size() > 0) return (m_ptr + k) % VC;
        return m_grant;
    endfunction

    function automatic bit all_empty();
        for (int v = 0; v < VC; v++)
            if (mq[v].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    initial begin : model
        int          g;
        int          wv;
        bit          v_ok;
        logic [FW:0] f;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int v = 0; v < VC; v++) mq[v].delete();
                m_ptr = 0; m_grant = 0; m_lock = 1'b0; m_hold = 1'b0;
            end else begin
                g    = cur_grant();
                v_ok = mq[g].size() > 0;
                wv   = -1;
                for (int v = 0; v < VC; v++)
                    if (bus.i_valid[v] && mq[v].size() < DEPTH && wv < 0) wv = v;
                if (v_ok && bus.i_ready) begin
                    f = mq[g].pop_front();
                    if (f[FW]) begin
                        m_lock = 1'b0;
                        m_ptr  = (g + 1) % VC;
                    end else begin
                        m_lock = 1'b1;
                    end
                end
                m_hold  = v_ok && !bus.i_ready;
                m_grant = g;
                if (wv >= 0) mq[wv].push_back({bus.i_tail, bus.i_flit});
            end
        end
    end

    initial begin : monitor
        int             g;
        bit             ev;
        logic [VC-1:0]  exp_ready;
        logic [VC-1:0]  exp_vc;
        forever begin
            @(negedge clk);
            g  = cur_grant();
            ev = mq[g].size() > 0;
            for (int v = 0; v < VC; v++) exp_ready[v] = mq[v].size() < DEPTH;
            exp_vc = ev ? (VC'(1) << g) : '0;
            check("mon_o_ready", bus.o_ready, exp_ready);
            check("mon_o_valid", bus.o_valid, ev);
            check("mon_o_vc", bus.o_vc, exp_vc);
            if (ev) check("mon_o_flit", {bus.o_tail, bus.o_flit}, mq[g][0]);
`ifdef NOC_VC_INPUT_BUFFER_COUNT_EN
            for (int v = 0; v < VC; v++)
                check("mon_o_count", o_count[v*CW +: CW], mq[v].size());
`endif
        end
    end

    function automatic logic [FW-1:0] rnd_flit();
        logic [FW-1:0] r;
        for (int i = 0; i < FW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Inputs applied here are sampled at the next rising edge; returns 1ns after it.
    task automatic drive(input logic [VC-1:0] v, input logic [FW-1:0] f, input logic t,
                         input logic r);
        bus.i_valid = v;
        bus.i_flit  = f;
        bus.i_tail  = t;
        bus.i_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Drains everything; feeds a tail to a locked VC that has run dry.
    task automatic drain(input int budget);
        int n    = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            if (all_empty() && !m_lock) done = 1'b1;
            else if (m_lock && mq[m_grant].size() == 0)
                drive(VC'(1) << m_grant, rnd_flit(), 1'b1, 1'b1);
            else drive('0, '0, 1'b0, 1'b1);
            n++;
        end
        check("drain_done", done, 1'b1);
    endtask

    initial begin : stim
        bus.i_valid = '0; bus.i_flit = '0; bus.i_tail = 1'b0; bus.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state, then a single tail flit on VC0.
        check("rst_o_ready", bus.o_ready, 2'b11);
        check("rst_o_valid", bus.o_valid, 1'b0);
        check("rst_o_vc", bus.o_vc, 2'b00);
        check("rst_o_flit", bus.o_flit, '0);
        drive(2'b01, FW'('hA5), 1'b1, 1'b0);
        check("t1_valid", bus.o_valid, 1'b1);
        check("t1_flit", bus.o_flit, 'hA5);
        check("t1_vc", bus.o_vc, 2'b01);
        check("t1_tail", bus.o_tail, 1'b1);
        drive('0, '0, 1'b0, 1'b1);
        check("t1_gone", bus.o_valid, 1'b0);

        // Fill VC1, overflow attempt, then in-order drain.
        for (int i = 0; i < 4; i++) drive(2'b10, FW'('h100 + i), i == 3, 1'b0);
        check("t2_full_ready1", bus.o_ready[1], 1'b0);
        check("t2_ready0", bus.o_ready[0], 1'b1);
        drive(2'b10, FW'('h1FF), 1'b1, 1'b0);
        check("t2_still_full", bus.o_ready[1], 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t2_order_flit", bus.o_flit, 'h100 + i);
            check("t2_order_vc", bus.o_vc, 2'b10);
            drive('0, '0, 1'b0, 1'b1);
        end
        check("t2_empty", bus.o_valid, 1'b0);

        // Two buffered 3-flit packets: no interleaving.
        for (int i = 0; i < 3; i++) drive(2'b01, FW'('h300 + i), i == 2, 1'b0);
        for (int i = 0; i < 3; i++) drive(2'b10, FW'('h310 + i), i == 2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("t3_vc", bus.o_vc, (i < 3) ? 2'b01 : 2'b10);
            check("t3_flit", bus.o_flit, (i < 3) ? ('h300 + i) : ('h310 + i - 3));
            check("t3_tail", bus.o_tail, (i == 2) || (i == 5));
            drive('0, '0, 1'b0, 1'b1);
        end

        // Single-flit packets on alternating VCs.
        for (int i = 0; i < 8; i++) drive((i % 2) ? 2'b10 : 2'b01, FW'('h400 + i), 1'b1, 1'b1);
        drain(50);

        // Backpressure on VC1 while VC0 receives flits.
        drive(2'b10, FW'('h5A), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("t5_hold_vc", bus.o_vc, 2'b10);
            check("t5_hold_flit", bus.o_flit, 'h5A);
            drive(2'b01, FW'('h550 + i), 1'b1, 1'b0);
        end
        check("t5_hold_vc_end", bus.o_vc, 2'b10);
        drain(50);

        // Locked VC0 runs dry; VC1 must wait for VC0's tail.
        drive(2'b01, FW'('h600), 1'b0, 1'b1);
        drive(2'b10, FW'('h610), 1'b1, 1'b1);
        drive(2'b10, FW'('h611), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t6_stall_valid", bus.o_valid, 1'b0);
            drive('0, '0, 1'b0, 1'b1);
        end
        drive(2'b01, FW'('h601), 1'b1, 1'b1);
        check("t6_tail_vc", bus.o_vc, 2'b01);
        check("t6_tail_flit", bus.o_flit, 'h601);
        drive('0, '0, 1'b0, 1'b1);
        check("t6_then_vc1", bus.o_vc, 2'b10);
        check("t6_then_flit", bus.o_flit, 'h610);
        drain(50);

        // Reset pulse mid-packet.
        drive(2'b01, FW'('h700), 1'b0, 1'b1);
        drive(2'b10, FW'('h710), 1'b0, 1'b1);
        drive(2'b01, FW'('h701), 1'b0, 1'b0);
        bus.i_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_valid", bus.o_valid, 1'b0);
        check("rstmid_ready", bus.o_ready, 2'b11);
        check("rstmid_vc", bus.o_vc, 2'b00);
`ifdef NOC_VC_INPUT_BUFFER_COUNT_EN
        check("rstmid_count", o_count, '0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic, checked by the monitor against the model.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [VC-1:0] v;
            sel = $urandom_range(0, 3);
            v   = (sel == 1) ? 2'b01 : (sel == 2) ? 2'b10 : 2'b00;
            drive(v, rnd_flit(), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
        end
        drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
